// File: rtl/proc_pkg.sv
// proc_pkg: opcode constants, reserved-opcode test and sequencer state type shared with the 9-bit processor
package proc_pkg;

    localparam logic [2:0] OP_MV  = 3'b000;
    localparam logic [2:0] OP_MVI = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_OPERAND,
        S_WAIT,
        S_HALT
    } seq_state_t;

    function automatic logic is_reserved(input logic [2:0] op);
        return op[2];
    endfunction

endpackage

// File: rtl/prog_ram.sv
// prog_ram: 2^ADDR_W x DATA_W program store; clk_50 write port (we/waddr/wdata), async read port (raddr/rdata), no reset
module prog_ram #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 9
) (
    input  logic              clk_50,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [0:2**ADDR_W-1];

    always_ff @(posedge clk_50)
        if (we) mem[waddr] <= wdata;

    assign rdata = mem[raddr];

endmodule

// File: rtl/program_sequencer.sv
// program_sequencer: feeds DIN/Run to the processor from prog_ram (Start/Stop control, prog_* load port, Done handshake; PC/Busy/Halted/Error/Instr_count status)
module program_sequencer
    import proc_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 9,
    parameter int TMO    = 7
) (
    input  logic              clk_50,
    input  logic              Resetn,
    input  logic              Start,
    input  logic              Stop,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_data,
    input  logic              Done,
    output logic [DATA_W-1:0] DIN,
    output logic              Run,
    output logic [ADDR_W-1:0] PC,
    output logic              Busy,
    output logic              Halted,
    output logic              Error,
    output logic [7:0]        Instr_count
);

    localparam int TW = $clog2(TMO + 1);

    seq_state_t        state, state_nx;
    logic [ADDR_W-1:0] pc_nx;
    logic [DATA_W-1:0] din_nx, rd;
    logic [7:0]        cnt_nx;
    logic              err_nx;
    logic [TW-1:0]     tmo, tmo_nx;
    logic              idle_like;

    assign idle_like = state == S_IDLE || state == S_HALT;

    prog_ram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_ram (
        .clk_50(clk_50),
        .we(prog_we && idle_like),
        .waddr(prog_addr),
        .wdata(prog_data),
        .raddr(PC),
        .rdata(rd)
    );

    always_comb begin
        state_nx = state;
        pc_nx    = PC;
        din_nx   = DIN;
        cnt_nx   = Instr_count;
        err_nx   = Error;
        tmo_nx   = tmo;
        case (state)
            S_IDLE, S_HALT:
                if (Start) begin
                    pc_nx    = '0;
                    cnt_nx   = '0;
                    err_nx   = 1'b0;
                    state_nx = S_FETCH;
                end
            S_FETCH:
                if (Stop) state_nx = S_IDLE;
                else if (is_reserved(rd[DATA_W-1 -: 3])) state_nx = S_HALT;
                else begin
                    din_nx   = rd;
                    pc_nx    = PC + 1'b1;
                    state_nx = S_ISSUE;
                end
            S_ISSUE: begin
                tmo_nx = '0;
                // DIN still holds the opcode; for MVI the next word is the immediate
                if (DIN[DATA_W-1 -: 3] == OP_MVI) begin
                    din_nx   = rd;
                    pc_nx    = PC + 1'b1;
                    state_nx = S_OPERAND;
                end else state_nx = S_WAIT;
            end
            S_OPERAND, S_WAIT:
                if (Done) begin
                    cnt_nx   = &Instr_count ? Instr_count : Instr_count + 1'b1;
                    state_nx = Stop ? S_IDLE : S_FETCH;
                end else if (tmo == TW'(TMO - 1)) begin
                    err_nx   = 1'b1;
                    state_nx = S_HALT;
                end else tmo_nx = tmo + 1'b1;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_50 or negedge Resetn)
        if (!Resetn) begin
            state       <= S_IDLE;
            PC          <= '0;
            DIN         <= '0;
            Instr_count <= '0;
            Error       <= 1'b0;
            tmo         <= '0;
        end else begin
            state       <= state_nx;
            PC          <= pc_nx;
            DIN         <= din_nx;
            Instr_count <= cnt_nx;
            Error       <= err_nx;
            tmo         <= tmo_nx;
        end

    assign Run    = state == S_ISSUE;
    assign Busy   = !idle_like;
    assign Halted = state == S_HALT;

endmodule

// File: tb/tb_program_sequencer.sv
// tb_program_sequencer: trace-model bench for program_sequencer (default instance plus an ADDR_W=2 wrap instance)
module tb_program_sequencer;

    localparam int TMO = 7;

    typedef struct {
        bit         run, busy, halted, err, done, stop;
        logic [8:0] din;
        int         pc, cnt;
    } rec_t;

    logic       clk_50 = 0, Resetn = 0, Start = 0, Stop = 0, prog_we = 0, Done = 0, sel = 0;
    logic [4:0] prog_addr = 0;
    logic [8:0] prog_data = 0;
    logic [8:0] din0, din1, o_din;
    logic [4:0] pc0, o_pc;
    logic [1:0] pc1;
    logic [7:0] cnt0, cnt1, o_cnt;
    logic       run0, run1, busy0, busy1, halt0, halt1, err0, err1;
    logic       o_run, o_busy, o_halt, o_err;

    rec_t       tr[$];
    logic [8:0] mem_m [0:31];
    logic [8:0] m_din = 0;
    int         total = 0, bad = 0, cyc = 0;

    always #10 clk_50 = ~clk_50;

    program_sequencer dut0 (
        .clk_50(clk_50), .Resetn(Resetn), .Start(Start & !sel), .Stop(Stop & !sel),
        .prog_we(prog_we & !sel), .prog_addr(prog_addr), .prog_data(prog_data), .Done(Done & !sel),
        .DIN(din0), .Run(run0), .PC(pc0), .Busy(busy0), .Halted(halt0), .Error(err0), .Instr_count(cnt0)
    );

    program_sequencer #(.ADDR_W(2)) dut1 (
        .clk_50(clk_50), .Resetn(Resetn), .Start(Start & sel), .Stop(Stop & sel),
        .prog_we(prog_we & sel), .prog_addr(prog_addr[1:0]), .prog_data(prog_data), .Done(Done & sel),
        .DIN(din1), .Run(run1), .PC(pc1), .Busy(busy1), .Halted(halt1), .Error(err1), .Instr_count(cnt1)
    );

    assign o_din  = sel ? din1 : din0;
    assign o_pc   = sel ? {3'b0, pc1} : pc0;
    assign o_cnt  = sel ? cnt1 : cnt0;
    assign o_run  = sel ? run1 : run0;
    assign o_busy = sel ? busy1 : busy0;
    assign o_halt = sel ? halt1 : halt0;
    assign o_err  = sel ? err1 : err0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s (step %0d): got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic rec_t mk(bit run, bit busy, bit halted, bit err, logic [8:0] din, int pc, int cnt,
                                bit done, bit stop);
        rec_t r;
        r.run = run; r.busy = busy; r.halted = halted; r.err = err; r.din = din;
        r.pc = pc; r.cnt = cnt; r.done = done; r.stop = stop;
        return r;
    endfunction

    // Walks the program instruction by instruction and expands it into the cycle trace the
    // sequencer must produce, including the Done/Stop the processor stand-in will drive.
    function automatic void gen(int aw, int stop_at, bit done_on);
        int pc = 0, cnt = 0, lat, mask = (1 << aw) - 1;
        logic [8:0] w;
        tr.delete();
        for (int k = 0; k < 64; k++) begin
            w = mem_m[pc];
            tr.push_back(mk(0, 1, 0, 0, m_din, pc, cnt, 0, 0));
            if (w[8]) begin
                tr.push_back(mk(0, 0, 1, 0, m_din, pc, cnt, 0, 0));
                return;
            end
            m_din = w;
            pc = (pc + 1) & mask;
            tr.push_back(mk(1, 1, 0, 0, m_din, pc, cnt, 0, 0));
            lat = (w[8:6] == 3'b000) ? 1 : 3;
            if (w[8:6] == 3'b001) begin
                m_din = mem_m[pc];
                pc = (pc + 1) & mask;
            end
            if (!done_on) begin
                for (int i = 0; i < TMO; i++) tr.push_back(mk(0, 1, 0, 0, m_din, pc, cnt, 0, 0));
                tr.push_back(mk(0, 0, 1, 1, m_din, pc, cnt, 0, 0));
                return;
            end
            for (int i = 1; i <= lat; i++)
                tr.push_back(mk(0, 1, 0, 0, m_din, pc, cnt, i == lat, i == lat && k == stop_at));
            cnt = cnt < 255 ? cnt + 1 : 255;
            if (k == stop_at) begin
                tr.push_back(mk(0, 0, 0, 0, m_din, pc, cnt, 0, 0));
                return;
            end
        end
    endfunction

    task automatic load(input int a, input logic [8:0] d);
        @(negedge clk_50);
        prog_we = 1; prog_addr = 5'(a); prog_data = d;
        mem_m[a] = d;
        @(negedge clk_50);
        prog_we = 0;
    endtask

    task automatic start();
        @(negedge clk_50);
        Start = 1;
    endtask

    // Compares every cycle of the trace; with junk set it also hammers the program
    // memory with reserved words while busy, which must have no effect.
    task automatic play(input bit junk);
        for (int i = 0; i < tr.size(); i++) begin
            @(negedge clk_50);
            cyc = i;
            Start = 0;
            chk("Run", o_run, tr[i].run);
            chk("Busy", o_busy, tr[i].busy);
            chk("Halted", o_halt, tr[i].halted);
            chk("Error", o_err, tr[i].err);
            chk("DIN", o_din, tr[i].din);
            chk("PC", o_pc, tr[i].pc);
            chk("Instr_count", o_cnt, tr[i].cnt);
            Done = tr[i].done;
            Stop = tr[i].stop;
            prog_we = junk && tr[i].busy;
            prog_addr = 5'(i % 8);
            prog_data = 9'o777;
        end
        prog_we = 0;
    endtask

    initial begin
        #5;
        chk("rst Run", o_run, 0);
        chk("rst Busy", o_busy, 0);
        chk("rst Halted", o_halt, 0);
        chk("rst Error", o_err, 0);
        chk("rst PC", o_pc, 0);
        chk("rst DIN", o_din, 0);
        chk("rst Instr_count", o_cnt, 0);
        @(negedge clk_50);
        Resetn = 1;

        load(0, 9'o017); load(1, 9'o400);
        gen(5, -1, 1);
        chk("mv len", tr.size(), 5);
        chk("mv issue din", tr[1].din, 9'o017);
        chk("mv end pc", tr[4].pc, 1);
        chk("mv end cnt", tr[4].cnt, 1);
        start(); play(0);

        load(0, 9'o100); load(1, 9'h05A); load(2, 9'o400);
        gen(5, -1, 1);
        chk("mvi imm din", tr[2].din, 9'h05A);
        chk("mvi held din", tr[4].din, 9'h05A);
        chk("mvi pc", tr[5].pc, 2);
        start(); play(0);

        load(0, 9'o201);
        gen(5, -1, 0);
        chk("tmo len", tr.size(), 10);
        chk("tmo err", tr[9].err, 1);
        start(); play(0);

        load(0, 9'o017); load(1, 9'o100); load(2, 9'h1FF); load(3, 9'o310);
        load(4, 9'o023); load(5, 9'o400);
        gen(5, 2, 1);
        chk("stop err cleared", tr[0].err, 0);
        chk("stop pc", tr[tr.size()-1].pc, 4);
        start(); play(1);
        gen(5, -1, 1);
        chk("rerun end pc", tr[tr.size()-1].pc, 5);
        start(); play(0);

        @(negedge clk_50);
        Stop = 1; Start = 1;
        @(negedge clk_50);
        Start = 0;
        chk("fetch stop busy", o_busy, 1);
        chk("fetch stop pc", o_pc, 0);
        @(negedge clk_50);
        chk("fetch stop idle", o_busy, 0);
        chk("fetch stop halted", o_halt, 0);
        chk("fetch stop run", o_run, 0);
        Stop = 0;

        load(0, 9'o201); load(1, 9'o400);
        start();
        @(negedge clk_50);
        Start = 0;
        @(negedge clk_50);
        chk("pre-rst Run", o_run, 1);
        @(negedge clk_50);
        chk("pre-rst wait", o_busy, 1);
        #2 Resetn = 0;
        #1;
        chk("mid rst Run", o_run, 0);
        chk("mid rst Busy", o_busy, 0);
        chk("mid rst PC", o_pc, 0);
        chk("mid rst DIN", o_din, 0);
        chk("mid rst Error", o_err, 0);
        @(negedge clk_50);
        Resetn = 1;
        m_din = 0;
        gen(5, -1, 1);
        start(); play(0);

        sel = 1;
        m_din = 0;
        load(0, 9'h003); load(1, 9'o012); load(2, 9'o012); load(3, 9'o100);
        gen(2, 3, 1);
        chk("wrap mvi din", tr[10].din, 9'o100);
        chk("wrap imm", tr[11].din, 9'h003);
        chk("wrap pc", tr[tr.size()-1].pc, 1);
        start(); play(0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/program_sequencer.md
# program_sequencer

Instruction feeder that sits directly upstream of the 9-bit processor. It holds a small writable program memory and a program counter, and drives the processor's `DIN` and `Run` inputs one instruction at a time. It waits for `Done` before issuing the next instruction, and for MVI it supplies the immediate word on the following cycle. It halts on a reserved opcode, and halts with an error flag if the processor never answers.

## Interface
Parameters:
- `ADDR_W`, default 5: program memory address width; depth is 2^ADDR_W words.
- `DATA_W`, default 9: instruction/data word width; must match the processor bus.
- `TMO`, default 7: maximum cycles spent waiting for `Done` before an error is flagged.

Ports:
- `clk_50`  in  1  system clock; all state updates on the rising edge.
- `Resetn`  in  1  reset, asynchronous, active-low.
- `Start`  in  1  level-sampled; starts execution from address 0.
- `Stop`  in  1  level-sampled; requests a return to IDLE after the current instruction.
- `prog_we`  in  1  program memory write enable.
- `prog_addr`  in  ADDR_W  program memory write address.
- `prog_data`  in  DATA_W  program memory write data.
- `Done`  in  1  completion flag from the processor.
- `DIN`  out  DATA_W  registered word driven to the processor.
- `Run`  out  1  one-cycle issue strobe to the processor.
- `PC`  out  ADDR_W  address of the next word to fetch.
- `Busy`  out  1  high in FETCH, ISSUE, OPERAND and WAIT.
- `Halted`  out  1  high in HALT.
- `Error`  out  1  sticky timeout flag.
- `Instr_count`  out  8  number of completed instructions, saturating.

## Operation
- States: IDLE, FETCH, ISSUE, OPERAND, WAIT, HALT.
- Opcode is `word[8:6]`. MV = 000, MVI = 001, ADD = 010, SUB = 011; 1xx is reserved.
- IDLE/HALT:
  - `Run` = 0; `DIN` holds its last value.
  - `prog_we` writes `mem[prog_addr]` <= `prog_data`. Writes in any other state are ignored.
  - `Start` = 1: PC <= 0, `Instr_count` <= 0, `Error` <= 0, next state FETCH.
- FETCH (memory read is asynchronous):
  - `mem[PC]` opcode is 1xx: go to HALT; PC unchanged; nothing issued.
  - Otherwise: `DIN` <= `mem[PC]`, PC <= PC+1, go to ISSUE.
- ISSUE:
  - `Run` = 1 for exactly this one cycle.
  - Opcode MVI: `DIN` <= `mem[PC]` (the immediate), PC <= PC+1, go to OPERAND.
  - Otherwise: go to WAIT.
- OPERAND/WAIT:
  - `DIN` is held stable.
  - The timeout counter clears on entry and increments each cycle.
  - `Done` = 1: `Instr_count` <= `Instr_count`+1 (saturates at 255). Go to IDLE if `Stop` = 1 in that same cycle, else FETCH.
  - Counter reaches TMO with `Done` still 0: `Error` <= 1, go to HALT.
- `Done` is sampled only in OPERAND and WAIT. It is ignored in every other state.
- PC arithmetic is modulo 2^ADDR_W. Fetching from the last address wraps PC to 0; this also applies to an MVI whose immediate lies at address 0.
- `Stop` is ignored outside OPERAND/WAIT, except that `Stop` = 1 in FETCH forces IDLE before any issue.
- `Start` and `prog_we` in the same cycle: the write commits first, so the following FETCH sees the new data.

## Timing
- Reset values:
  - State IDLE; PC = 0; `DIN` = 0; `Run` = 0; `Busy` = 0; `Halted` = 0; `Error` = 0; `Instr_count` = 0.
  - Memory contents are not reset.
- Reset asserted mid-operation returns everything to the reset values immediately; `Run` drops asynchronously.
- Latency from `Start` to `Run`: 2 cycles (IDLE→FETCH→ISSUE).
- Per-instruction cost: 1 cycle FETCH + 1 cycle ISSUE + wait cycles up to and including `Done`. With the processor's T1..T3 sequencing, MV takes 3 cycles and ADD/SUB/MVI take 5.
- `DIN` changes only on the FETCH→ISSUE and ISSUE→OPERAND edges.
- The immediate is valid from the first cycle after `Run`, i.e. during the processor's T1.
- `Run` never goes high in two consecutive cycles.
- `Busy`, `Halted` and `Run` are decoded combinationally from the registered state.

## Structure
- Shared package `proc_pkg` holds:
  - the opcode constants `OP_MV`, `OP_MVI`, `OP_ADD`, `OP_SUB`;
  - the reserved-opcode test function;
  - the `seq_state_t` enum.
- Sub-module `prog_ram`: 2^ADDR_W × DATA_W words, single write port clocked by `clk_50`, asynchronous read port, no reset.
- Top-level contents: the FSM, PC, `DIN` register, timeout counter and instruction counter.

## Test plan
- **MV program:** load mem[0] = 9'o017 (MV R1,R7), mem[1] = 9'o400; pulse `Start`.
  - `Run` is high 2 cycles after `Start`, with `DIN` = 9'o017.
  - Model `Done` at the first WAIT cycle.
  - Then HALT with PC = 1, `Instr_count` = 1, `Error` = 0.
- **MVI:** mem[0] = 9'o100 (MVI R0), mem[1] = 9'h05A.
  - `DIN` = 9'o100 during `Run`, then 9'h05A in the following cycle, held until `Done`.
  - PC = 2 afterwards.
- **Timeout:** issue an ADD with `Done` tied low.
  - `Error` = 1 and HALT entered TMO cycles after ISSUE.
  - `Start` then clears `Error`.
- **Wrap-around:** ADDR_W = 2, mem[3] = MVI, mem[0] = immediate 9'h003.
  - Immediate is fetched from address 0; PC = 1 afterwards.
- **Stop and write rules:**
  - Assert `Stop` with `Done` mid-program: IDLE, PC points at the next instruction.
  - `prog_we` while `Busy` leaves memory unchanged, checked by readback via re-execution.
- **Reset mid-WAIT:**
  - All outputs return to reset values in the same cycle; `Run` = 0.
  - A later `Start` re-executes from address 0.
